// File: rtl/ps2_keyboard_transmitter_pkg.sv
// Shared PS/2 device-side constants, FSM state encoding and frame builder.
package ps2_keyboard_transmitter_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic        PS2_START      = 1'b0;
  localparam logic        PS2_STOP       = 1'b1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StClkHigh = 3'd2,
    StClkLow  = 3'd3,
    StGap     = 3'd4,
    StInhibit = 3'd5
  } ps2_tx_state_e;

  // Bit 0 goes on the wire first: start, data LSB first, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {PS2_STOP, ~^data, data, PS2_START};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte queue; the head is visible on rdata without popping.
module ps2_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CountW = AddrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CountW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AddrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_transmitter.sv
// PS/2 keyboard-side transmitter: generates the PS/2 clock and shifts queued scancodes out,
// backing off and resending the whole byte whenever the host inhibits mid-frame.
module ps2_keyboard_transmitter
  import ps2_keyboard_transmitter_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2000,
  parameter int unsigned GAP_CYCLES  = 4000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic       busy
);

  localparam int unsigned MaxCycles = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;
  localparam int unsigned CountW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TimerW-1:0] HalfLast = TimerW'(HALF_PERIOD - 1);
  localparam logic [TimerW-1:0] GapLast  = TimerW'(GAP_CYCLES - 1);
  localparam logic [3:0]        LastBit  = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_e               state;
  logic [TimerW-1:0]           timer;
  logic [3:0]                  bit_idx;
  logic [PS2_FRAME_BITS-2:0]   shreg;
  logic [PS2_FRAME_BITS-1:0]   head_frame;
  logic [7:0]                  fifo_rdata;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic [CountW-1:0]           fifo_count;

  assign tx_ready   = !fifo_full;
  assign busy       = (state != StIdle) || (fifo_count != '0);
  assign head_frame = ps2_frame(fifo_rdata);
  // The byte leaves the queue only once its stop bit has been clocked out.
  assign fifo_pop   = (state == StClkLow) && (timer == HalfLast) && (bit_idx == LastBit);

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid && tx_ready),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      ps2_clk_out <= 1'b1;
      ps2_dat_out <= 1'b1;
    end else begin
      timer <= timer + TimerW'(1);
      case (state)
        StIdle: begin
          timer <= '0;
          if (!fifo_empty && ps2_clk_in) state <= StLoad;
        end
        StLoad: begin
          shreg       <= head_frame[PS2_FRAME_BITS-1:1];
          ps2_dat_out <= head_frame[0];
          bit_idx     <= '0;
          timer       <= '0;
          state       <= StClkHigh;
        end
        StClkHigh: begin
          // Host pulling the clock low while we release it means inhibit; the stop bit is exempt.
          if (!ps2_clk_in && (bit_idx < LastBit)) begin
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            timer       <= '0;
            state       <= StInhibit;
          end else if (timer == HalfLast) begin
            ps2_clk_out <= 1'b0;
            timer       <= '0;
            state       <= StClkLow;
          end
        end
        StClkLow: begin
          if (timer == HalfLast) begin
            ps2_clk_out <= 1'b1;
            timer       <= '0;
            if (bit_idx < LastBit) begin
              bit_idx     <= bit_idx + 4'd1;
              ps2_dat_out <= shreg[0];
              shreg       <= shreg >> 1;
              state       <= StClkHigh;
            end else begin
              state <= StGap;
            end
          end
        end
        StGap: begin
          if (timer == GapLast) begin
            timer <= '0;
            state <= StIdle;
          end
        end
        StInhibit: begin
          // Gap timing restarts whenever the host is still holding the clock low.
          if (!ps2_clk_in) begin
            timer <= '0;
          end else if (timer == GapLast) begin
            timer <= '0;
            state <= StIdle;
          end
        end
        default: begin
          timer <= '0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_transmitter.sv
// Bench for ps2_keyboard_transmitter: a PS/2 host receiver model samples data on each
// clock falling edge and checks decoded frames against a queue of accepted bytes.
module tb_ps2_keyboard_transmitter;

  localparam int unsigned HP    = 4;
  localparam int unsigned GAP   = 10;
  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_clk_out;
  logic       ps2_dat_out;
  logic       busy;
  logic       host_inhibit = 1'b0;

  // Open-collector clock line: either end can pull it low.
  assign ps2_clk_in = ps2_clk_out & ~host_inhibit;

  always #5 clk = ~clk;

  ps2_keyboard_transmitter #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_clk_out (ps2_clk_out),
    .ps2_dat_out (ps2_dat_out),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  logic [7:0]  exp_q[$];
  logic [10:0] raw_q[$];
  int          model_occ = 0;
  int          cyc = 0, nbits = 0, hi_run = 0, frames = 0, falls = 0;
  int          rise_cyc = 0, start_cyc = 0, last_gap = 0;
  logic        prev_clk = 1'b1, prev_dat = 1'b1;
  logic [10:0] bits = '0;
  logic [7:0]  rx_byte;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      nbits = 0;
    end else begin
      hi_run = ps2_clk_out ? hi_run + 1 : 0;
      if (hi_run > int'(HP) + 1) nbits = 0;  // clock parked high: host drops partial frame
      if (prev_clk && !ps2_clk_out) begin
        falls++;
        bits[4'(nbits)] = ps2_dat_out;
        nbits++;
        if (nbits == 11) begin
          rx_byte = bits[8:1];
          check_eq("rx_start", bits[0], 1'b0);
          check_eq("rx_stop", bits[10], 1'b1);
          check_eq("rx_parity_odd", $countones(bits[9:1]) % 2, 1);
          check_eq("rx_expected_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check_eq("rx_byte", rx_byte, exp_q.pop_front());
          raw_q.push_back(bits);
          frames++;
          if (model_occ > 0) model_occ--;
          nbits = 0;
        end
      end
      if (!prev_clk && ps2_clk_out) rise_cyc = cyc;
      if (prev_dat && !ps2_dat_out && ps2_clk_out && nbits == 0) begin
        last_gap  = cyc - rise_cyc;
        start_cyc = cyc;
      end
    end
    prev_clk = ps2_clk_out;
    prev_dat = ps2_dat_out;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic exp_rdy;
    exp_rdy = (model_occ < int'(DEPTH));
    check_eq("tx_ready", tx_ready, exp_rdy);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    if (exp_rdy) begin
      exp_q.push_back(b);
      model_occ++;
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int i = 0;
    while (busy && i < bound) begin
      step();
      i++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic wait_bits(input string tag, input int n, input int bound);
    int i = 0;
    while (!(nbits == n && ps2_clk_out) && i < bound) begin
      step();
      i++;
    end
    check_eq(tag, (nbits == n) && ps2_clk_out, 1'b1);
  endtask

  initial begin
    logic [10:0] fr;
    logic [7:0]  b;
    int          i, f0, n, hold;

    repeat (3) step();
    check_eq("rst_clk", ps2_clk_out, 1'b1);
    check_eq("rst_dat", ps2_dat_out, 1'b1);
    check_eq("rst_ready", tx_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();

    // Single byte: latency, wire bits, frame length, trailing gap
    push_byte(8'h1C);
    check_eq("t1_dat_e0", ps2_dat_out, 1'b1);
    step();
    check_eq("t1_dat_e1", ps2_dat_out, 1'b1);
    step();
    check_eq("t1_dat_e2", ps2_dat_out, 1'b0);
    wait_idle("t1_idle", 300);
    fr = raw_q[raw_q.size()-1];
    check_eq("t1_bits", fr, 11'b100_0011_1000);
    check_eq("t1_span", rise_cyc - start_cyc, 22 * HP);
    check_eq("t1_busy_drop", cyc - rise_cyc, GAP);

    // Back-to-back bytes
    push_byte(8'hF0);
    push_byte(8'h1C);
    wait_idle("t2_idle", 400);
    check_eq("t2_gap", last_gap, GAP + 2);
    fr = raw_q[raw_q.size()-2];
    check_eq("t2_f0_parity", fr[9], 1'b1);

    // Fill while host blocks, overflow attempt, then drain
    host_inhibit = 1'b1;
    step();
    for (int k = 0; k < 9; k++) push_byte(8'($urandom));
    check_eq("t3_full_ready", tx_ready, 1'b0);
    check_eq("t3_busy", busy, 1'b1);
    check_eq("t3_held_clk", ps2_clk_out, 1'b1);
    check_eq("t3_queued", exp_q.size(), DEPTH);
    host_inhibit = 1'b0;
    wait_idle("t3_idle", 1200);
    check_eq("t3_drained", exp_q.size(), 0);

    // Inhibit in bit 5 high phase: release, no pop, full resend
    f0 = frames;
    push_byte(8'h1C);
    wait_bits("t4_reach_bit5", 5, 200);
    host_inhibit = 1'b1;
    step();
    check_eq("t4_clk_rel", ps2_clk_out, 1'b1);
    check_eq("t4_dat_rel", ps2_dat_out, 1'b1);
    check_eq("t4_busy", busy, 1'b1);
    repeat (19) step();
    host_inhibit = 1'b0;
    i = 0;
    while (ps2_dat_out && i < 50) begin
      step();
      i++;
    end
    check_eq("t4_restart", i, GAP + 2);
    wait_idle("t4_idle", 300);
    check_eq("t4_frames", frames - f0, 1);

    // Reset mid-frame
    push_byte(8'h00);
    wait_bits("t5_reach_bit3", 3, 200);
    reset = 1'b1;
    step();
    check_eq("t5_clk", ps2_clk_out, 1'b1);
    check_eq("t5_dat", ps2_dat_out, 1'b1);
    check_eq("t5_ready", tx_ready, 1'b1);
    check_eq("t5_busy", busy, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    model_occ = 0;
    f0 = falls;
    repeat (50) step();
    check_eq("t5_no_edges", falls, f0);

    // Parity corners
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle("t6_idle", 400);
    fr = raw_q[raw_q.size()-2];
    check_eq("t6_par_00", fr[9], 1'b1);
    fr = raw_q[raw_q.size()-1];
    check_eq("t6_par_ff", fr[9], 1'b1);

    // Random bursts
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        push_byte(8'($urandom));
        repeat ($urandom_range(0, 3)) step();
      end
      wait_idle("rnd_burst_idle", 1000);
    end

    // Random inhibit points, including the stop bit where inhibit is ignored
    for (int k = 0; k < 6; k++) begin
      b    = 8'($urandom);
      n    = (k == 0) ? 10 : $urandom_range(1, 10);
      hold = $urandom_range(1, 20);
      f0   = frames;
      push_byte(b);
      wait_bits("rnd_reach_bit", n, 300);
      host_inhibit = 1'b1;
      repeat (hold) step();
      host_inhibit = 1'b0;
      wait_idle("rnd_inh_idle", 400);
      check_eq("rnd_inh_frames", frames - f0, 1);
    end
    check_eq("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
